// File: rtl/dmem_miss_ctrl.sv
// Data-miss sequencer: squashes/rewinds/parks a missing thread and refills one cache line.
// Latency: miss_flush same cycle; replay/park next cycle; fill writes 1 cycle after each beat.
// Backpressure: refill_req held with a stable address until refill_gnt; beats may have gaps.
module dmem_miss_ctrl #(
    parameter int NTRD       = 8,
    parameter int LINE_WORDS = 4,
    localparam int TRD_W     = (NTRD > 1) ? $clog2(NTRD) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       pc_mem,
    input  logic [TRD_W-1:0]  trd_mem,
    input  logic              d_miss,
    output logic              miss_flush,
    output logic              replay_valid,
    output logic [31:0]       replay_pc,
    output logic [TRD_W-1:0]  replay_trd,
    output logic [NTRD-1:0]   sleep_mask,
    output logic [NTRD-1:0]   wake_mask,
    output logic              refill_req,
    output logic [31:0]       refill_addr,
    input  logic              refill_gnt,
    input  logic              refill_rvalid,
    input  logic [31:0]       refill_rdata,
    output logic              fill_we,
    output logic [31:0]       fill_addr,
    output logic [31:0]       fill_data,
    output logic              busy
);

    // Beat counter width and the byte-offset mask of one line.
    localparam int          CNT_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [31:0] OFF_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q,        state_d;
    logic [CNT_W-1:0]   cnt_q,          cnt_d;
    logic [31:0]        base_q,         base_d;
    logic               replay_valid_q, replay_valid_d;
    logic [31:0]        replay_pc_q,    replay_pc_d;
    logic [TRD_W-1:0]   replay_trd_q,   replay_trd_d;
    logic [NTRD-1:0]    sleep_q,        sleep_d;
    logic [NTRD-1:0]    wake_q,         wake_d;
    logic               fill_we_q,      fill_we_d;
    logic [31:0]        fill_addr_q,    fill_addr_d;
    logic [31:0]        fill_data_q,    fill_data_d;

    logic               miss;
    logic [31:0]        line_base;
    logic [31:0]        beat_offset;

    // Only a real load/store can miss; a stray d_miss without an access is ignored.
    assign miss        = d_miss & (d_rd | d_wr);
    assign line_base   = d_addr & ~OFF_MASK;
    assign beat_offset = {{(32-CNT_W-2){1'b0}}, cnt_q, 2'b00};

    // Next-state and registered-output logic for the single MSHR.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        base_d         = base_q;
        replay_valid_d = miss;
        replay_pc_d    = replay_pc_q;
        replay_trd_d   = replay_trd_q;
        sleep_d        = sleep_q;
        wake_d         = '0;
        fill_we_d      = 1'b0;
        fill_addr_d    = fill_addr_q;
        fill_data_d    = fill_data_q;

        if (miss) begin
            replay_pc_d  = pc_mem;
            replay_trd_d = trd_mem;
        end

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    base_d  = line_base;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Secondary misses only park; the request itself is untouched.
                if (refill_gnt) begin
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (refill_rvalid) begin
                    fill_we_d   = 1'b1;
                    fill_addr_d = base_q + beat_offset;
                    fill_data_d = refill_rdata;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Release everyone parked on this line; a miss here starts the next refill.
                wake_d  = sleep_q;
                sleep_d = '0;
                if (miss) begin
                    base_d  = line_base;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Parking the missing thread overrides the DONE-cycle clear.
        if (miss) begin
            sleep_d[trd_mem] = 1'b1;
        end
    end

    // State and output registers; reset abandons any request or burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            base_q         <= '0;
            replay_valid_q <= 1'b0;
            replay_pc_q    <= '0;
            replay_trd_q   <= '0;
            sleep_q        <= '0;
            wake_q         <= '0;
            fill_we_q      <= 1'b0;
            fill_addr_q    <= '0;
            fill_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            base_q         <= base_d;
            replay_valid_q <= replay_valid_d;
            replay_pc_q    <= replay_pc_d;
            replay_trd_q   <= replay_trd_d;
            sleep_q        <= sleep_d;
            wake_q         <= wake_d;
            fill_we_q      <= fill_we_d;
            fill_addr_q    <= fill_addr_d;
            fill_data_q    <= fill_data_d;
        end
    end

    assign miss_flush   = miss;
    assign replay_valid = replay_valid_q;
    assign replay_pc    = replay_pc_q;
    assign replay_trd   = replay_trd_q;
    assign sleep_mask   = sleep_q;
    assign wake_mask    = wake_q;
    assign refill_req   = (state_q == S_REQ);
    assign refill_addr  = base_q;
    assign fill_we      = fill_we_q;
    assign fill_addr    = fill_addr_q;
    assign fill_data    = fill_data_q;
    assign busy         = (state_q != S_IDLE);

endmodule
